// File: rtl/wb_initiator.sv
// Wishbone classic initiator: converts one cmd_* request into a single bus cycle
// and returns a response on rsp_*. An abort is signalled when the slave never acks.
module wb_initiator #(
    parameter int unsigned TIMEOUT         = 255,
    parameter logic [15:0] TXN_COUNT_RESET = 16'h0000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_n_i,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [31:0] cmd_adr,
    input  logic [31:0] cmd_dat,
    input  logic [3:0]  cmd_sel,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_dat,
    output logic        rsp_err,
    output logic        wbs_cyc_i,
    output logic        wbs_stb_i,
    output logic        wbs_we_i,
    output logic [31:0] wbs_adr_i,
    output logic [31:0] wbs_dat_i,
    output logic [3:0]  wbs_sel_i,
    input  logic        wbs_ack_o,
    input  logic [31:0] wbs_dat_o,
    output logic [15:0] txn_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUS,
        S_RESP
    } state_t;

    localparam logic [16:0] TIMEOUT_W = 17'(TIMEOUT);

    state_t      r_state;
    logic [15:0] r_timer;
    logic        r_cmd_ready;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_dat;
    logic        r_rsp_err;
    logic        r_cyc;
    logic        r_stb;
    logic        r_we;
    logic [31:0] r_adr;
    logic [31:0] r_wdat;
    logic [3:0]  r_sel;
    logic [15:0] r_txn_count;

    logic        w_timeout;

    // Abort on the edge where this cycle would be the TIMEOUT-th BUS cycle without ack.
    assign w_timeout = (TIMEOUT != 0) && (({1'b0, r_timer} + 17'd1) == TIMEOUT_W);

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_state     <= S_IDLE;
            r_timer     <= 16'd0;
            r_cmd_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_dat   <= 32'd0;
            r_rsp_err   <= 1'b0;
            r_cyc       <= 1'b0;
            r_stb       <= 1'b0;
            r_we        <= 1'b0;
            r_adr       <= 32'd0;
            r_wdat      <= 32'd0;
            r_sel       <= 4'd0;
            r_txn_count <= TXN_COUNT_RESET;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_cmd_ready <= 1'b0;
                        r_cyc       <= 1'b1;
                        r_stb       <= 1'b1;
                        r_we        <= cmd_we;
                        r_adr       <= cmd_adr;
                        r_wdat      <= cmd_we ? cmd_dat : 32'd0;
                        r_sel       <= cmd_sel;
                        r_timer     <= 16'd0;
                        r_state     <= S_BUS;
                    end
                end

                S_BUS: begin
                    // Ack is checked first so it wins over a timeout on the same edge.
                    if (wbs_ack_o || w_timeout) begin
                        r_cyc       <= 1'b0;
                        r_stb       <= 1'b0;
                        r_we        <= 1'b0;
                        r_adr       <= 32'd0;
                        r_wdat      <= 32'd0;
                        r_sel       <= 4'd0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                        if (wbs_ack_o) begin
                            r_rsp_dat   <= r_we ? 32'd0 : wbs_dat_o;
                            r_rsp_err   <= 1'b0;
                            r_txn_count <= r_txn_count + 16'd1;
                        end else begin
                            r_rsp_dat   <= 32'd0;
                            r_rsp_err   <= 1'b1;
                        end
                    end else begin
                        r_timer <= r_timer + 16'd1;
                    end
                end

                S_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_rsp_dat   <= 32'd0;
                        r_rsp_err   <= 1'b0;
                        r_cmd_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end

                default: begin
                    r_state     <= S_IDLE;
                    r_cmd_ready <= 1'b1;
                    r_cyc       <= 1'b0;
                    r_stb       <= 1'b0;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready = r_cmd_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_dat   = r_rsp_dat;
    assign rsp_err   = r_rsp_err;
    assign wbs_cyc_i = r_cyc;
    assign wbs_stb_i = r_stb;
    assign wbs_we_i  = r_we;
    assign wbs_adr_i = r_adr;
    assign wbs_dat_i = r_wdat;
    assign wbs_sel_i = r_sel;
    assign txn_count = r_txn_count;

endmodule

// File: tb/tb_wb_initiator.sv
// Bench for wb_initiator: directed cases plus random transactions against a
// transaction-level model (ack after N waits, abort after TIMEOUT silent cycles).
module tb_wb_initiator;

    localparam int unsigned TO      = 4;
    localparam logic [15:0] PRELOAD = 16'hFFFD;

    logic clk = 1'b0;
    logic rstN = 1'b0;
    always #5 clk = ~clk;

    logic        cmdValid, cmdWe, rspReady, wbAck;
    logic [31:0] cmdAdr, cmdDat, wbDatO;
    logic [3:0]  cmdSel;

    logic        cmdReady, rspValid, rspErr, cyc, stb, we;
    logic [31:0] rspDat, adr, wdat;
    logic [3:0]  sel;
    logic [15:0] txnCount;

    logic        cmdReady2, rspValid2, rspErr2, cyc2, stb2, we2;
    logic [31:0] rspDat2, adr2, wdat2;
    logic [3:0]  sel2;
    logic [15:0] txnCount2;

    wb_initiator #(.TIMEOUT(TO)) dut (
        .wb_clk_i(clk), .wb_rst_n_i(rstN),
        .cmd_valid(cmdValid), .cmd_ready(cmdReady), .cmd_we(cmdWe),
        .cmd_adr(cmdAdr), .cmd_dat(cmdDat), .cmd_sel(cmdSel),
        .rsp_valid(rspValid), .rsp_ready(rspReady), .rsp_dat(rspDat), .rsp_err(rspErr),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we),
        .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_sel_i(sel),
        .wbs_ack_o(wbAck), .wbs_dat_o(wbDatO), .txn_count(txnCount)
    );

    // Second instance starts its counter near the top so the 16-bit wrap is reached quickly.
    wb_initiator #(.TIMEOUT(TO), .TXN_COUNT_RESET(PRELOAD)) dut2 (
        .wb_clk_i(clk), .wb_rst_n_i(rstN),
        .cmd_valid(cmdValid), .cmd_ready(cmdReady2), .cmd_we(cmdWe),
        .cmd_adr(cmdAdr), .cmd_dat(cmdDat), .cmd_sel(cmdSel),
        .rsp_valid(rspValid2), .rsp_ready(rspReady), .rsp_dat(rspDat2), .rsp_err(rspErr2),
        .wbs_cyc_i(cyc2), .wbs_stb_i(stb2), .wbs_we_i(we2),
        .wbs_adr_i(adr2), .wbs_dat_i(wdat2), .wbs_sel_i(sel2),
        .wbs_ack_o(wbAck), .wbs_dat_o(wbDatO), .txn_count(txnCount2)
    );

    int checks = 0;
    int errors = 0;
    logic [15:0] modelCount  = 16'd0;
    logic [15:0] modelCount2 = PRELOAD;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One full transaction: slave acks after 'waits' silent cycles unless the timeout fires first.
    task automatic applyStimulus(input logic w, input logic [31:0] a, input logic [31:0] d,
                                 input logic [3:0] s, input int waits, input logic [31:0] rd,
                                 input int rspDelay, input bit noisy);
        logic        expErr;
        logic [31:0] expDat;
        int          k;
        bit          done;
        checkOutput("idle_ready", cmdReady, 1);
        checkOutput("idle_cyc", {cyc, stb}, 0);
        cmdValid = 1; cmdWe = w; cmdAdr = a; cmdDat = d; cmdSel = s;
        tick;
        cmdValid = 0; cmdWe = ~w; cmdAdr = $urandom; cmdDat = $urandom; cmdSel = ~s;
        done = 0; k = 0; expErr = 0; expDat = 0;
        while (!done) begin
            checkOutput("bus_cycstb", {cyc, stb}, 2'b11);
            checkOutput("bus_cyc2", cyc2, 1);
            checkOutput("bus_we", we, w);
            checkOutput("bus_adr", adr, a);
            checkOutput("bus_dat", wdat, w ? d : 32'd0);
            checkOutput("bus_sel", sel, s);
            checkOutput("bus_ready", cmdReady, 0);
            cmdValid = $urandom_range(0, 1);
            wbAck  = (k == waits);
            wbDatO = (k == waits) ? rd : $urandom;
            tick;
            wbAck = 0; cmdValid = 0;
            if (k == waits) begin
                expErr = 0; expDat = w ? 32'd0 : rd;
                modelCount++; modelCount2++;
                done = 1;
            end else if (k + 1 == TO) begin
                expErr = 1; expDat = 0;
                done = 1;
            end
            k++;
        end
        for (int i = 0; i <= rspDelay; i++) begin
            checkOutput("rsp_valid", rspValid, 1);
            checkOutput("rsp_cycstb", {cyc, stb}, 0);
            checkOutput("rsp_err", rspErr, expErr);
            checkOutput("rsp_dat", rspDat, expDat);
            checkOutput("rsp_count", txnCount, modelCount);
            checkOutput("rsp_count2", txnCount2, modelCount2);
            checkOutput("rsp_valid2", {rspValid2, rspErr2}, {1'b1, expErr});
            checkOutput("rsp_dat2", rspDat2, expDat);
            checkOutput("rsp_ready", cmdReady, 0);
            if (i == rspDelay) begin
                rspReady = 1;
            end else begin
                rspReady = 0;
                wbAck    = noisy ? (i % 2 == 0) : 1'($urandom_range(0, 1));
                wbDatO   = $urandom;
                cmdValid = noisy ? 1'b1 : 1'($urandom_range(0, 1));
            end
            tick;
            rspReady = 0; wbAck = 0; cmdValid = 0;
        end
        checkOutput("done_valid", rspValid, 0);
        checkOutput("done_ready", cmdReady, 1);
        checkOutput("done_cyc", cyc, 0);
        checkOutput("done_count", txnCount, modelCount);
    endtask

    task automatic idleAck;
        wbAck = 1; wbDatO = $urandom;
        tick;
        wbAck = 0;
        checkOutput("idleack_cyc", {cyc, stb}, 0);
        checkOutput("idleack_ready", cmdReady, 1);
        checkOutput("idleack_valid", rspValid, 0);
        checkOutput("idleack_count", txnCount, modelCount);
    endtask

    task automatic checkResetValues;
        checkOutput("rst_cycstbwe", {cyc, stb, we}, 0);
        checkOutput("rst_adr", adr, 0);
        checkOutput("rst_dat", wdat, 0);
        checkOutput("rst_sel", sel, 0);
        checkOutput("rst_rsp", {rspValid, rspErr}, 0);
        checkOutput("rst_rspdat", rspDat, 0);
        checkOutput("rst_count", txnCount, 0);
        checkOutput("rst_count2", txnCount2, PRELOAD);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        cmdValid = 0; cmdWe = 0; cmdAdr = 0; cmdDat = 0; cmdSel = 0;
        rspReady = 0; wbAck = 0; wbDatO = 0;
        repeat (2) @(posedge clk);
        #1;
        checkResetValues();
        rstN = 1;
        #1;
        checkOutput("post_rst_ready", cmdReady, 1);
        #1;

        // Directed: 2-wait write, zero-wait read, timeout, held-off response with noise.
        applyStimulus(1'b1, 32'h3000_0004, 32'h0000_0015, 4'hF, 2, 32'h0, 0, 1'b0);
        applyStimulus(1'b0, 32'h3000_0000, 32'hDEAD_BEEF, 4'hF, 0, 32'h0000_0022, 0, 1'b0);
        applyStimulus(1'b1, 32'h3000_0008, 32'h1234_5678, 4'h3, 99, 32'h0, 0, 1'b0);
        applyStimulus(1'b0, 32'h3000_000C, 32'h0, 4'hF, 1, 32'hA5A5_5A5A, 5, 1'b1);
        idleAck();

        // Reset asserted in the middle of a bus cycle.
        cmdValid = 1; cmdWe = 1; cmdAdr = 32'h3000_0010; cmdDat = 32'h77; cmdSel = 4'hF;
        tick;
        cmdValid = 0;
        checkOutput("midrst_cyc_before", {cyc, stb}, 2'b11);
        tick;
        #3;
        rstN = 0;
        #1;
        checkResetValues();
        modelCount  = 16'd0;
        modelCount2 = PRELOAD;
        tick;
        rstN = 1;

        // Ack on the timeout edge wins; three successes also carry dut2 through its wrap.
        applyStimulus(1'b0, 32'h3000_0014, 32'h0, 4'hF, TO - 1, 32'h0BAD_F00D, 0, 1'b0);
        applyStimulus(1'b1, 32'h3000_0018, 32'h55, 4'h1, 0, 32'h0, 1, 1'b0);
        applyStimulus(1'b0, 32'h3000_001C, 32'h0, 4'h8, 1, 32'hCAFE_0001, 2, 1'b0);
        checkOutput("wrap_count2", txnCount2, 16'h0000);

        for (int n = 0; n < 40; n++) begin
            applyStimulus(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)),
                          int'($urandom_range(0, TO + 1)), $urandom,
                          int'($urandom_range(0, 3)), 1'b0);
            if ($urandom_range(0, 3) == 0) idleAck();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
